czonotope_serializer: RTL and testbench

Streams a constrained zonotope held on a `CZonotope` interface out as a flat word sequence over a valid/ready channel. The sequence is: header (n, ng, nc), then c, G, A and b. It is the read-out end of the set-operation datapath. `intersection`, `linear_image` and similar blocks write a `CZonotope`, and this block reads one back out to a host link, FIFO or the next processing stage without exposing the full parallel structure.

---
 rtl/czono_pkg.sv | 23 ++
 rtl/czonotope_if.sv | 21 ++
 rtl/czono_idx_counter.sv | 53 +++++
 rtl/czonotope_serializer.sv | 188 ++++++++++++++++++
 tb/tb_czonotope_serializer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/czono_pkg.sv
// Shared types and helpers for the constrained-zonotope serializer.
package czono_pkg;

    // Serializer sections in stream order, plus idle and completion.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SC,
        SG,
        SA,
        SB,
        DONE
    } ser_state_t;

    // Header carries n, ng, nc.
    localparam int HDR_WORDS = 3;

    // Bits needed to hold a dimension value in the range 0..max_v.
    function automatic int dim_w(input int max_v);
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/czonotope_if.sv
// Parallel view of a constrained zonotope: centre c, generators G,
// constraint matrix A and constraint vector b, with live dimensions.
interface CZonotope
    import czono_pkg::*;
#(
    parameter int NMAX       = 512,
    parameter int NGMAX      = 512,
    parameter int NCMAX      = 512,
    parameter int DATA_WIDTH = 32
);
    logic [dim_w(NMAX)-1:0]  n;
    logic [dim_w(NGMAX)-1:0] ng;
    logic [dim_w(NCMAX)-1:0] nc;
    logic [DATA_WIDTH-1:0]   c [NMAX];
    logic [DATA_WIDTH-1:0]   G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0]   A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0]   b [NCMAX];

    // Reader side: everything is an input.
    modport snk (input n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czono_idx_counter.sv
// Row/column walker for one matrix or vector section. Column wraps
// into the next row; after the last element both indices return to 0.
module czono_idx_counter #(
    parameter int RIW = 9,
    parameter int CIW = 9,
    parameter int RLW = 10,
    parameter int CLW = 10
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [RLW-1:0] row_lim_i,
    input  logic [CLW-1:0] col_lim_i,
    output logic [RIW-1:0] row_o,
    output logic [CIW-1:0] col_o,
    output logic           last_col_o,
    output logic           last_o
);
    logic [RIW-1:0] row_q, row_d;
    logic [CIW-1:0] col_q, col_d;

    assign last_col_o = (CLW'(col_q) == col_lim_i - CLW'(1));
    assign last_o     = last_col_o && (RLW'(row_q) == row_lim_i - RLW'(1));
    assign row_o      = row_q;
    assign col_o      = col_q;

    // Next index: wrap column into the row, wrap everything at section end.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i || (en_i && last_o)) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i && last_col_o) begin
            row_d = row_q + RIW'(1);
            col_d = '0;
        end else if (en_i) begin
            col_d = col_q + CIW'(1);
        end
    end

    // Index registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/czonotope_serializer.sv
// Streams a CZonotope as header(n,ng,nc), c, G, A, b over valid/ready.
// The output word register is refilled whenever it is empty or being
// taken, so a held-high ready gives one word per cycle across sections.
module czonotope_serializer
    import czono_pkg::*;
#(
    parameter int NMAX       = 512,
    parameter int NGMAX      = 512,
    parameter int NCMAX      = 512,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    CZonotope.snk                 Z,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int NW     = dim_w(NMAX);
    localparam int GW     = dim_w(NGMAX);
    localparam int CW     = dim_w(NCMAX);
    localparam int RW_RAW = (NW > CW) ? NW : CW;
    localparam int RW     = (RW_RAW < 2) ? 2 : RW_RAW;
    localparam int NIW    = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int GIW    = (NGMAX > 1) ? $clog2(NGMAX) : 1;
    localparam int CIW    = (NCMAX > 1) ? $clog2(NCMAX) : 1;
    localparam int RI_RAW = (NIW > CIW) ? NIW : CIW;
    localparam int RIW    = (RI_RAW < 2) ? 2 : RI_RAW;

    localparam logic [NW-1:0] NMAX_V  = NW'(NMAX);
    localparam logic [GW-1:0] NGMAX_V = GW'(NGMAX);
    localparam logic [CW-1:0] NCMAX_V = CW'(NCMAX);

    ser_state_t            state_q, next_sec;
    logic [NW-1:0]         n_q;
    logic [GW-1:0]         ng_q;
    logic [CW-1:0]         nc_q;
    logic [DATA_WIDTH-1:0] data_q, word_d;
    logic                  valid_q, last_q, busy_q, done_q, err_q;

    logic [RW-1:0]  row_lim;
    logic [GW-1:0]  col_lim;
    logic [RIW-1:0] row_w;
    logic [GIW-1:0] col_w;
    logic           last_col_w, cnt_last_w, sec_end_w;
    logic           in_sec_w, load_w, overflow_w;

    assign in_sec_w   = (state_q == HDR) || (state_q == SC) || (state_q == SG) ||
                        (state_q == SA)  || (state_q == SB);
    assign load_w     = in_sec_w && (!valid_q || m_ready_i);
    assign sec_end_w  = last_col_w && cnt_last_w;
    assign overflow_w = (Z.n > NMAX_V) || (Z.ng > NGMAX_V) || (Z.nc > NCMAX_V);

    czono_idx_counter #(
        .RIW(RIW),
        .CIW(GIW),
        .RLW(RW),
        .CLW(GW)
    ) u_idx (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clr_i      (state_q == IDLE),
        .en_i       (load_w),
        .row_lim_i  (row_lim),
        .col_lim_i  (col_lim),
        .row_o      (row_w),
        .col_o      (col_w),
        .last_col_o (last_col_w),
        .last_o     (cnt_last_w)
    );

    // Section extents for the counter; vectors are one column wide.
    always_comb begin
        row_lim = RW'(1);
        col_lim = GW'(1);
        case (state_q)
            HDR:     row_lim = RW'(HDR_WORDS);
            SC:      row_lim = RW'(n_q);
            SG:      begin row_lim = RW'(n_q);  col_lim = ng_q; end
            SA:      begin row_lim = RW'(nc_q); col_lim = ng_q; end
            SB:      row_lim = RW'(nc_q);
            default: ;
        endcase
    end

    // Next non-empty section after the current one ends; DONE if none.
    always_comb begin
        next_sec = DONE;
        case (state_q)
            HDR: next_sec = SC;
            SC: begin
                if (ng_q != '0)      next_sec = SG;
                else if (nc_q != '0) next_sec = SB;
            end
            SG: if (nc_q != '0) next_sec = SA;
            SA: next_sec = SB;
            default: next_sec = DONE;
        endcase
    end

    // Section mux: pick the entry addressed by the walker.
    always_comb begin
        word_d = '0;
        case (state_q)
            HDR: begin
                case (row_w[1:0])
                    2'd0:    word_d = DATA_WIDTH'(n_q);
                    2'd1:    word_d = DATA_WIDTH'(ng_q);
                    default: word_d = DATA_WIDTH'(nc_q);
                endcase
            end
            SC:      word_d = Z.c[row_w[NIW-1:0]];
            SG:      word_d = Z.G[row_w[NIW-1:0]][col_w];
            SA:      word_d = Z.A[row_w[CIW-1:0]][col_w];
            SB:      word_d = Z.b[row_w[CIW-1:0]];
            default: word_d = '0;
        endcase
    end

    // Control FSM, dimension latch and held output register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            ng_q    <= '0;
            nc_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q  <= Z.n;
                        ng_q <= Z.ng;
                        nc_q <= Z.nc;
                        if (overflow_w) begin
                            err_q <= 1'b1;
                        end else if (Z.n == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= HDR;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                HDR, SC, SG, SA, SB: begin
                    if (load_w) begin
                        data_q  <= word_d;
                        valid_q <= 1'b1;
                        if (sec_end_w) begin
                            state_q <= next_sec;
                            last_q  <= (next_sec == DONE);
                        end
                    end
                end
                DONE: begin
                    if (!valid_q || m_ready_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_czonotope_serializer.sv
// Directed bench for czonotope_serializer with small dimension limits.
module tb_czonotope_serializer;
    import czono_pkg::*;

    localparam int NM   = 4;
    localparam int NG   = 4;
    localparam int NC   = 4;
    localparam int DW   = 32;
    localparam int DIMW = dim_w(4);

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o, m_last_o, busy_o, done_o, err_o;

    CZonotope #(.NMAX(NM), .NGMAX(NG), .NCMAX(NC), .DATA_WIDTH(DW)) zif ();

    czonotope_serializer #(.NMAX(NM), .NGMAX(NG), .NCMAX(NC), .DATA_WIDTH(DW)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .Z         (zif),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // n=2, ng=3, nc=1 and n=3, ng=2, nc=0 with the fill pattern below.
    logic [31:0] exp15 [15] = '{32'd2, 32'd3, 32'd1, 32'h100, 32'h101,
                                32'h200, 32'h201, 32'h202, 32'h210, 32'h211, 32'h212,
                                32'h300, 32'h301, 32'h302, 32'h400};
    logic [31:0] exp12 [12] = '{32'd3, 32'd2, 32'd0, 32'h100, 32'h101, 32'h102,
                                32'h200, 32'h201, 32'h210, 32'h211, 32'h220, 32'h221};

    logic [31:0] got_d [$];
    logic        got_l [$];
    int          stall_bad, done_cyc, first_hs, last_hs;
    logic        busy_at_done;
    bit          timed_out;
    logic [15:0] lfsr = 16'hACE1;

    task automatic set_dims(input int n, input int ng, input int nc);
        zif.n  = DIMW'(n);
        zif.ng = DIMW'(ng);
        zif.nc = DIMW'(nc);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Sink: records handshaken words, stall stability and done timing.
    task automatic cap(input bit rnd, input int poke, input bit restart, input int budget);
        logic [31:0]     hold_d;
        logic            hold_l;
        bit              holding;
        logic [DIMW-1:0] saved;
        got_d.delete(); got_l.delete();
        stall_bad = 0; done_cyc = -1; first_hs = -1; last_hs = -1;
        busy_at_done = 1'b1; timed_out = 1'b0; holding = 1'b0;
        hold_d = '0; hold_l = 1'b0; saved = zif.ng;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (holding && (!m_valid_o || m_data_o !== hold_d || m_last_o !== hold_l))
                stall_bad++;
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                busy_at_done = busy_o;
                if (restart) start_i = 1'b1;
                @(posedge clk); #1;
                start_i = 1'b0;
                return;
            end
            if (cyc == poke) begin
                saved = zif.ng;
                zif.ng = DIMW'(1);
                start_i = 1'b1;
            end
            if (cyc == poke + 1) start_i = 1'b0;
            if (cyc == poke + 4) zif.ng = saved;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            m_ready_i = rnd ? lfsr[0] : 1'b1;
            if (m_valid_o && m_ready_i) begin
                got_d.push_back(m_data_o);
                got_l.push_back(m_last_o);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                holding = 1'b0;
            end else if (m_valid_o) begin
                holding = 1'b1;
                hold_d  = m_data_o;
                hold_l  = m_last_o;
            end else begin
                holding = 1'b0;
            end
            @(posedge clk); #1;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        total++; if (m_data_o !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", m_data_o); end
        total++; if ({m_last_o, done_o, err_o} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {m_last_o, done_o, err_o}); end
        $display("reset: valid=%b busy=%b data=%h", m_valid_o, busy_o, m_data_o);
    endtask

    task automatic test_basic();
        set_dims(2, 3, 1);
        m_ready_i = 1'b1;
        pulse_start();
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", m_valid_o); end
        @(posedge clk); #1;
        total++; if ({m_valid_o, busy_o} !== 2'b11 || m_data_o !== 32'd2) begin
            bad++; $display("FAIL basic_latency got=v%b b%b %h want=v1 b1 00000002", m_valid_o, busy_o, m_data_o);
        end
        cap(1'b0, -10, 1'b0, 60);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
        total++; if (got_d.size() != 15) begin bad++; $display("FAIL basic_count got=%0d want=15", got_d.size()); end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp15[i] || got_l[i] !== (i == 14)) begin
                bad++; $display("FAIL basic_word%0d got=%h last=%b want=%h last=%b", i, got_d[i], got_l[i], exp15[i], i == 14);
            end
        end
        total++; if (first_hs != 0 || last_hs != 14) begin bad++; $display("FAIL basic_rate got=%0d..%0d want=0..14", first_hs, last_hs); end
        total++; if (done_cyc != last_hs + 1 || busy_at_done !== 1'b0) begin
            bad++; $display("FAIL basic_done got=cyc%0d busy%b want=cyc%0d busy0", done_cyc, busy_at_done, last_hs + 1);
        end
        $display("basic: words=%0d done_cyc=%0d", got_d.size(), done_cyc);
    endtask

    task automatic test_stall();
        set_dims(2, 3, 1);
        m_ready_i = 1'b0;
        pulse_start();
        cap(1'b1, -10, 1'b0, 200);
        total++; if (timed_out) begin bad++; $display("FAIL stall_timeout got=timeout want=done"); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_bad); end
        total++; if (got_d.size() != 15) begin bad++; $display("FAIL stall_count got=%0d want=15", got_d.size()); end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp15[i] || got_l[i] !== (i == 14)) begin
                bad++; $display("FAIL stall_word%0d got=%h last=%b want=%h last=%b", i, got_d[i], got_l[i], exp15[i], i == 14);
            end
        end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL stall_done got=%0d want=%0d", done_cyc, last_hs + 1); end
        $display("stall: words=%0d cycles=%0d", got_d.size(), done_cyc);
    endtask

    task automatic test_skip();
        set_dims(3, 2, 0);
        m_ready_i = 1'b1;
        pulse_start();
        cap(1'b0, -10, 1'b0, 60);
        total++; if (timed_out) begin bad++; $display("FAIL skip_timeout got=timeout want=done"); end
        total++; if (got_d.size() != 12) begin bad++; $display("FAIL skip_count got=%0d want=12", got_d.size()); end
        for (int i = 0; i < 12 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp12[i] || got_l[i] !== (i == 11)) begin
                bad++; $display("FAIL skip_word%0d got=%h last=%b want=%h last=%b", i, got_d[i], got_l[i], exp12[i], i == 11);
            end
        end
        total++; if (last_hs - first_hs != 11) begin bad++; $display("FAIL skip_rate got=%0d want=11", last_hs - first_hs); end
        $display("skip: words=%0d", got_d.size());
    endtask

    task automatic test_error();
        set_dims(2, NG + 1, 1);
        m_ready_i = 1'b1;
        pulse_start();
        total++; if ({err_o, m_valid_o, busy_o} !== 3'b100) begin
            bad++; $display("FAIL err_pulse got=e%b v%b b%b want=e1 v0 b0", err_o, m_valid_o, busy_o);
        end
        @(posedge clk); #1;
        total++; if ({err_o, m_valid_o, busy_o} !== 3'b000) begin
            bad++; $display("FAIL err_after got=e%b v%b b%b want=e0 v0 b0", err_o, m_valid_o, busy_o);
        end
        $display("error: ng=%0d rejected", NG + 1);
    endtask

    task automatic test_degenerate();
        set_dims(0, 2, 1);
        pulse_start();
        total++; if ({done_o, m_valid_o} !== 2'b00) begin bad++; $display("FAIL deg_k got=d%b v%b want=d0 v0", done_o, m_valid_o); end
        @(posedge clk); #1;
        total++; if ({done_o, m_valid_o, busy_o} !== 3'b100) begin
            bad++; $display("FAIL deg_done got=d%b v%b b%b want=d1 v0 b0", done_o, m_valid_o, busy_o);
        end
        @(posedge clk); #1;
        total++; if ({done_o, m_valid_o} !== 2'b00) begin bad++; $display("FAIL deg_after got=d%b v%b want=d0 v0", done_o, m_valid_o); end
        $display("degenerate: n=0 done");
    endtask

    task automatic test_reset_mid();
        int hs;
        bit hit;
        hs = 0;
        hit = 1'b0;
        set_dims(2, 3, 1);
        m_ready_i = 1'b1;
        pulse_start();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (m_valid_o && hs == 7) begin hit = 1'b1; break; end
            if (m_valid_o && m_ready_i) hs++;
            @(posedge clk); #1;
        end
        total++; if (!hit) begin bad++; $display("FAIL rmid_reach got=%0d want=7", hs); end
        #2 rstn_i = 1'b0;
        #1;
        total++; if ({m_valid_o, m_last_o, busy_o, done_o, err_o} !== 5'b0 || m_data_o !== 32'd0) begin
            bad++; $display("FAIL rmid_async got=v%b l%b b%b d%b e%b %h want=all zero",
                            m_valid_o, m_last_o, busy_o, done_o, err_o, m_data_o);
        end
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        cap(1'b0, -10, 1'b0, 60);
        total++; if (timed_out || got_d.size() != 15) begin bad++; $display("FAIL rmid_count got=%0d want=15", got_d.size()); end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp15[i] || got_l[i] !== (i == 14)) begin
                bad++; $display("FAIL rmid_word%0d got=%h last=%b want=%h last=%b", i, got_d[i], got_l[i], exp15[i], i == 14);
            end
        end
        $display("reset_mid: words after restart=%0d", got_d.size());
    endtask

    task automatic test_back_to_back();
        set_dims(2, 3, 1);
        m_ready_i = 1'b1;
        pulse_start();
        cap(1'b0, 4, 1'b1, 60);
        total++; if (timed_out || got_d.size() != 15) begin bad++; $display("FAIL b2b_first_count got=%0d want=15", got_d.size()); end
        for (int i = 0; i < 15 && i < got_d.size(); i++) begin
            total++; if (got_d[i] !== exp15[i] || got_l[i] !== (i == 14)) begin
                bad++; $display("FAIL b2b_word%0d got=%h last=%b want=%h last=%b", i, got_d[i], got_l[i], exp15[i], i == 14);
            end
        end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", m_valid_o); end
        @(posedge clk); #1;
        total++; if ({m_valid_o, busy_o} !== 2'b11 || m_data_o !== 32'd2) begin
            bad++; $display("FAIL b2b_restart got=v%b b%b %h want=v1 b1 00000002", m_valid_o, busy_o, m_data_o);
        end
        cap(1'b0, -10, 1'b0, 60);
        total++; if (timed_out || got_d.size() != 15) begin bad++; $display("FAIL b2b_second_count got=%0d want=15", got_d.size()); end
        $display("back_to_back: second words=%0d", got_d.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NM; i++) begin
            zif.c[i] = 32'h100 + i;
            for (int j = 0; j < NG; j++) zif.G[i][j] = 32'h200 + 16 * i + j;
        end
        for (int i = 0; i < NC; i++) begin
            zif.b[i] = 32'h400 + i;
            for (int j = 0; j < NG; j++) zif.A[i][j] = 32'h300 + 16 * i + j;
        end
        set_dims(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn_i = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_stall();
        test_skip();
        test_error();
        test_degenerate();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
